// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment BCD display scanner.
// Glyphs are active-high, bit order gfedcba (seg[0]=a).
package bcd_display_scanner_pkg;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned BCD_W    = 4;
  localparam int unsigned SEG_W    = 7;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  typedef logic [$clog2(N_DIGITS)-1:0] digit_idx_t;
  typedef logic [BCD_W-1:0]            nibble_t;

  function automatic logic [N_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
    logic [N_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_dec.sv
// Combinational BCD nibble to active-high 7-segment glyph decoder.
// Non-BCD codes (A..F) render as a dash so corrupt counts are visible.
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner with per-frame shadow latching,
// leading-zero blanking, decimal points and selectable output polarity.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter bit          LZ_BLANK   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_DIGITS*BCD_W-1:0] digits,
  input  logic [N_DIGITS-1:0]       dp_mask,
  input  logic                      enable,
  output logic [N_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]          seg,
  output logic                      dp,
  output logic                      frame_tick
);

  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  // XOR masks: active-high internal levels become board levels.
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]    SEG_INV = {SEG_W{ACTIVE_LOW}};
  localparam logic                DP_OFF  = ACTIVE_LOW;

  if (DIV < 2) begin : g_div_check
    $error("bcd_display_scanner: CLK_HZ/REFRESH_HZ must be at least 2");
  end

  logic [PW-1:0]               presc_q, presc_d;
  digit_idx_t                  idx_q, idx_d;
  logic [N_DIGITS*BCD_W-1:0]   shadow_digits_q, shadow_digits_d;
  logic [N_DIGITS-1:0]         shadow_dp_q, shadow_dp_d;
  logic                        frame_tick_q, frame_tick_d;
  logic [N_DIGITS-1:0]         an_q, an_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic                        dp_q, dp_d;

  logic                        tick;
  logic                        reload;
  logic [N_DIGITS-1:0]         blank;
  logic                        zero_above;
  nibble_t                     cur_nibble;
  logic [SEG_W-1:0]            glyph;
  logic                        cur_blank;
  logic                        cur_dp;
  logic [N_DIGITS-1:0]         an_act;
  logic [SEG_W-1:0]            seg_act;
  logic                        dp_act;

  always_comb begin
    tick            = (presc_q == PRESC_MAX);
    presc_d         = tick ? '0 : presc_q + 1'b1;
    idx_d           = tick ? idx_q + 1'b1 : idx_q;
    reload          = tick && (idx_q == digit_idx_t'(N_DIGITS - 1));
    shadow_digits_d = reload ? digits : shadow_digits_q;
    shadow_dp_d     = reload ? dp_mask : shadow_dp_q;
    frame_tick_d    = reload;
  end

  // Blank from the top down while every higher nibble (this one included) is zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (shadow_digits_q[k*BCD_W +: BCD_W] == '0);
      blank[k]   = LZ_BLANK && zero_above;
    end
  end

  always_comb begin
    cur_nibble = shadow_digits_q[idx_q*BCD_W +: BCD_W];
    cur_blank  = blank[idx_q];
    cur_dp     = shadow_dp_q[idx_q];
  end

  bcd_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  // A blanked digit keeps its anode on only to show a requested decimal point.
  always_comb begin
    an_act  = '0;
    seg_act = SEG_OFF;
    dp_act  = 1'b0;
    if (enable) begin
      dp_act = cur_dp;
      if (!cur_blank) begin
        an_act  = digit_onehot(idx_q);
        seg_act = glyph;
      end else if (cur_dp) begin
        an_act = digit_onehot(idx_q);
      end
    end
    an_d  = an_act ^ AN_OFF;
    seg_d = seg_act ^ SEG_INV;
    dp_d  = dp_act ^ DP_OFF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q         <= '0;
      idx_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      frame_tick_q    <= 1'b0;
      an_q            <= AN_OFF;
      seg_q           <= SEG_INV;
      dp_q            <= DP_OFF;
    end else begin
      presc_q         <= presc_d;
      idx_q           <= idx_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      frame_tick_q    <= frame_tick_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

  anode_onehot_a : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(an_q ^ AN_OFF));

endmodule
